// File: rtl/mux_pkg.sv
// Shared definitions for the channel-scanning mux sequencer:
// FSM state encoding, dwell default and a lowest-channel helper.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DWELL_DEFAULT = 5;
    localparam int CNT_W         = 4;

    // Lowest set bit of a 4-bit channel mask; returns 0 for an empty mask.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_ch = 2'(i);
        end
    endfunction

endpackage

// File: rtl/next_ch_enc.sv
// Finds the next set channel strictly above the current one in a 4-bit mask.
module next_ch_enc (
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    output logic [1:0] nxt,
    output logic       found
);

    // Descending scan so the nearest higher channel wins.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt   = 2'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_seq.sv
// Scans the channels of a downstream 4:1 mux: per selected channel it waits
// DWELL settle cycles, samples mux_out into its result slot, then advances.
module mux_sel_seq
    import mux_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ch_mask,
    input  logic [3:0]  mux_out,
    output logic [1:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  res_valid
);

    // Handshake: start is a level request honoured only while in IDLE; done
    // is a single-cycle completion pulse with no acknowledge required.

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask_q;
    logic [1:0]       nxt_ch;
    logic             nxt_found;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    next_ch_enc u_next_ch (
        .mask  (mask_q),
        .cur   (sel),
        .nxt   (nxt_ch),
        .found (nxt_found)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (ch_mask != 4'd0) ? SETTLE : DONE;
            SETTLE:  if (cnt == '0) state_n = SAMPLE;
            SAMPLE:  state_n = nxt_found ? SETTLE : DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mask_q    <= 4'd0;
            sel       <= 2'd0;
            result    <= 16'd0;
            res_valid <= 4'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q    <= ch_mask;
                        res_valid <= 4'd0;
                        if (ch_mask != 4'd0) begin
                            sel <= lowest_ch(ch_mask);
                            cnt <= CNT_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                SAMPLE: begin
                    result[{sel, 2'b00} +: 4] <= mux_out;
                    res_valid[sel]            <= 1'b1;
                    if (nxt_found) begin
                        sel <= nxt_ch;
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: DWELL=5 and DWELL=1 instances scan a fixed 4:1 mux
// (a=4, b=8, c=12, d=15) and are compared cycle by cycle with a trace model.
module tb_mux_sel_seq;

    typedef struct packed {
        logic [1:0]  sel;
        logic        busy;
        logic        done;
        logic [15:0] result;
        logic [3:0]  res_valid;
    } obs_t;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] exp_result;
        logic [3:0]  exp_valid;
        int          lat5;
        int          lat1;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [3:0]  ch_mask;
    logic [3:0]  mux_out5, mux_out1;
    logic [1:0]  sel5, sel1;
    logic        busy5, busy1, done5, done1;
    logic [15:0] result5, result1;
    logic [3:0]  res_valid5, res_valid1;

    function automatic logic [3:0] mux_data(input logic [1:0] ch);
        case (ch)
            2'd0:    mux_data = 4'd4;
            2'd1:    mux_data = 4'd8;
            2'd2:    mux_data = 4'd12;
            default: mux_data = 4'd15;
        endcase
    endfunction

    assign mux_out5 = mux_data(sel5);
    assign mux_out1 = mux_data(sel1);

    mux_sel_seq #(.DWELL(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
        .mux_out(mux_out5), .sel(sel5), .busy(busy5), .done(done5),
        .result(result5), .res_valid(res_valid5)
    );

    mux_sel_seq #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
        .mux_out(mux_out1), .sel(sel1), .busy(busy1), .done(done1),
        .result(result1), .res_valid(res_valid1)
    );

    // ---------------- reference model ----------------
    int   checks = 0;
    int   errors = 0;
    obs_t m5, m1;
    obs_t q5[$];
    obs_t q1[$];
    obs_t tq[$];

    // Whole-scan expected trace: per set channel d settle cycles plus one
    // sample cycle, then a DONE cycle and one IDLE cycle before a re-accept.
    function automatic void build_trace(input int d, input logic [3:0] m, input obs_t base);
        obs_t e;
        tq.delete();
        e           = base;
        e.res_valid = 4'd0;
        e.done      = 1'b0;
        e.busy      = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                e.sel  = 2'(ch);
                e.busy = 1'b1;
                for (int k = 0; k < d + 1; k++) tq.push_back(e);
                e.result[4*ch +: 4] = mux_data(2'(ch));
                e.res_valid[ch]     = 1'b1;
            end
        end
        e.busy = 1'b0;
        e.done = 1'b1;
        tq.push_back(e);
        e.done = 1'b0;
        tq.push_back(e);
    endfunction

    task automatic model_edge();
        if (rst) begin
            q5.delete(); m5 = '0;
            q1.delete(); m1 = '0;
        end else begin
            if (q5.size() > 0) m5 = q5.pop_front();
            else if (start) begin
                build_trace(5, ch_mask, m5); q5 = tq; m5 = q5.pop_front();
            end else begin
                m5.busy = 1'b0; m5.done = 1'b0;
            end
            if (q1.size() > 0) m1 = q1.pop_front();
            else if (start) begin
                build_trace(1, ch_mask, m1); q1 = tq; m1 = q1.pop_front();
            end else begin
                m1.busy = 1'b0; m1.done = 1'b0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("sel5",       32'(sel5),       32'(m5.sel));
        check("busy5",      32'(busy5),      32'(m5.busy));
        check("done5",      32'(done5),      32'(m5.done));
        check("result5",    32'(result5),    32'(m5.result));
        check("res_valid5", 32'(res_valid5), 32'(m5.res_valid));
        check("sel1",       32'(sel1),       32'(m1.sel));
        check("busy1",      32'(busy1),      32'(m1.busy));
        check("done1",      32'(done1),      32'(m1.done));
        check("result1",    32'(result1),    32'(m1.result));
        check("res_valid1", 32'(res_valid1), 32'(m1.res_valid));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (q5.size() == 0 && q1.size() == 0) break;
            step();
        end
        check("drain_timeout", 32'(q5.size() + q1.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[6];
    int   got5, got1, dcount;

    initial begin
        vecs[0] = '{4'b1010, 16'hF080, 4'b1010, 13, 5};
        vecs[1] = '{4'b0000, 16'hF080, 4'b0000,  1, 1};
        vecs[2] = '{4'b0001, 16'hF084, 4'b0001,  7, 3};
        vecs[3] = '{4'b0110, 16'hFC84, 4'b0110, 13, 5};
        vecs[4] = '{4'b1111, 16'hFC84, 4'b1111, 25, 9};
        vecs[5] = '{4'b1000, 16'hFC84, 4'b1000,  7, 3};

        rst = 1'b1; start = 1'b0; ch_mask = 4'd0;
        m5 = '0; m1 = '0;
        step(); step();
        check("rst_sel5",    32'(sel5),       32'd0);
        check("rst_result5", 32'(result5),    32'd0);
        check("rst_valid1",  32'(res_valid1), 32'd0);
        rst = 1'b0;
        step();

        // Table: single scans with fixed latency and result expectations.
        foreach (vecs[i]) begin
            ch_mask = vecs[i].mask;
            start   = 1'b1;
            got5 = -1; got1 = -1; dcount = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (c == 1) start = 1'b0;
                if (busy5 && vecs[i].mask == 4'd0) dcount++;
                if (done5 && got5 < 0) got5 = c;
                if (done1 && got1 < 0) got1 = c;
                if (got5 >= 0 && got1 >= 0) break;
            end
            check("lat5",      32'(got5),       32'(vecs[i].lat5));
            check("lat1",      32'(got1),       32'(vecs[i].lat1));
            check("tbl_res5",  32'(result5),    32'(vecs[i].exp_result));
            check("tbl_res1",  32'(result1),    32'(vecs[i].exp_result));
            check("tbl_val5",  32'(res_valid5), 32'(vecs[i].exp_valid));
            check("tbl_val1",  32'(res_valid1), 32'(vecs[i].exp_valid));
            if (vecs[i].mask == 4'd0) check("empty_busy", 32'(dcount), 32'd0);
            drain();
            step();
        end

        // Start held high across scans; mask wiggles mid-scan.
        ch_mask = 4'b0101;
        start   = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (c % 7 == 3) ch_mask = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        drain();
        step();

        // Reset during channel 2 settle.
        ch_mask = 4'b1111;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (m5.sel == 2'd2 && m5.busy) break;
            step();
        end
        check("pre_rst_sel5", 32'(sel5), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_sel5",   32'(sel5),       32'd0);
        check("mid_rst_busy5",  32'(busy5),      32'd0);
        check("mid_rst_res5",   32'(result5),    32'd0);
        check("mid_rst_valid5", 32'(res_valid5), 32'd0);
        dcount = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done5 || done1) dcount++;
        end
        check("no_done_after_rst", 32'(dcount), 32'd0);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1; ch_mask = 4'b1111;
        step();
        check("rst_prio_busy5", 32'(busy5), 32'd0);
        check("rst_prio_busy1", 32'(busy1), 32'd0);
        rst = 1'b0; start = 1'b0;
        step();

        // Randomized traffic against the trace model.
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            start   = ($urandom_range(0, 3) == 0);
            ch_mask = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0; start = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_seq.md
MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

Interface
REQ-001 The module SHALL have parameter DWELL, default 5, giving the settle cycles held per channel before sampling; legal range 1..15.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: scan request, sampled in IDLE only.
REQ-005 The module SHALL have port ch_mask, input, 4 bits: channels a..d to scan (bit0=a, bit3=d), latched on accepted start.
REQ-006 The module SHALL have port mux_out, input, 4 bits: data returned by the downstream 4:1 mux.
REQ-007 The module SHALL have port sel, output, 2 bits: channel select driven to the mux.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-010 The module SHALL have port result, output, 16 bits: captured samples; [4n+3:4n] holds channel n.
REQ-011 The module SHALL have port res_valid, output, 4 bits: bit n is set when result slot n was written by the last scan.

Function
REQ-012 The FSM SHALL use states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 In IDLE, start=1 with nonzero ch_mask SHALL latch the mask, clear res_valid, set sel to the lowest set channel, load the dwell counter with DWELL-1 and enter SETTLE.
REQ-014 In IDLE, start=1 with ch_mask=0 SHALL enter DONE directly, leaving result unchanged and clearing res_valid.
REQ-015 SETTLE SHALL decrement the dwell counter each cycle and enter SAMPLE in the cycle after the counter reaches 0, so exactly DWELL cycles are spent in SETTLE.
REQ-016 SAMPLE SHALL last one cycle: it writes mux_out into the result slot for sel and sets res_valid[sel].
REQ-017 From SAMPLE, if a higher set channel remains in the latched mask, the FSM SHALL set sel to the next higher set channel, reload the counter and enter SETTLE; otherwise it SHALL enter DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored outside IDLE, including in DONE; ch_mask changes during a scan SHALL have no effect.
REQ-021 sel SHALL hold its last value in IDLE and DONE and change only on channel advance.
REQ-022 Result slots of unmasked channels SHALL retain their prior values.
REQ-023 Latency from the start-accept edge to done=1 SHALL be k*(DWELL+1)+1 cycles for k set mask bits.

Reset
REQ-024 rst=1 at any clock edge, including mid-scan, SHALL force IDLE, sel=0, busy=0, done=0, result=0, res_valid=0, dwell counter=0 and latched mask=0.
REQ-025 rst SHALL take priority over start in the same cycle.

Structure
REQ-026 State encodings (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and the DWELL default SHALL live in shared package mux_pkg.
REQ-027 Next-channel selection SHALL be a sub-module named next_ch_enc (inputs: 4-bit mask, 2-bit current channel; outputs: next channel and a found flag).
REQ-028 The bench SHALL instantiate mux_sel_seq driving the existing 4:1 mux, using a=4, b=8, c=12, d=15.

Verification
REQ-029 Full scan: mask=1111, DWELL=5, start pulsed -> sel steps 0,1,2,3; done arrives 25 cycles after accept; result=16'hFC84; res_valid=1111.
REQ-030 Sparse scan: mask=1010 -> sel visits 1 then 3 only; result[7:4]=8 and result[15:12]=15; other slots unchanged; res_valid=1010; done arrives 13 cycles after accept.
REQ-031 Empty mask: mask=0000 with start -> done pulses the next cycle; busy is never 1; result is unchanged.
REQ-032 Busy restart: start held high through a scan -> the second scan begins only from IDLE after DONE; no sel glitch occurs mid-scan.
REQ-033 Reset mid-scan: rst asserted during SETTLE of channel 2 -> the next cycle shows sel=0, busy=0, result=0 and res_valid=0, and no done pulse occurs.
REQ-034 DWELL=1 corner: mask=1111 -> each channel spends 1 SETTLE and 1 SAMPLE cycle; done arrives 9 cycles after accept.
